force_release_ctrl: RTL and testbench

Parametrised force/release overlay for emulation-side signal control. It sits between a design driver and its load, replacing a selected part of a WIDTH-bit bus with a force value. Force is triggered by the rising edge of an enable, and release happens on the falling edge, on command, on timeout or on driver change, depending on the mode. It is the generalised successor of the fixed 4-bit, level-edge force block: runtime bit mask, four release modes, timed hold and forced-bit status.

---
 rtl/force_release_ctrl.sv | 61 ++++++
 tb/tb_force_release_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/force_release_ctrl.sv
// force_release_ctrl: masked force/release overlay with level, sticky, timed and deposit release modes
module force_release_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_drv,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_val,
   input  logic [WIDTH-1:0] i_mask,
   input  logic [1:0]       i_mode,
   input  logic             i_release,
   input  logic [CNT_W-1:0] i_hold,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_forced,
   output logic             o_busy
);
   logic             en_d;
   logic [WIDTH-1:0] forced_r, fval_r, snap_r;
   logic [1:0]       mode_r;
   logic [CNT_W-1:0] cnt_r;
   logic             rise, fall, busy, rel_all;
   logic [WIDTH-1:0] dep_clr, forced_nxt, fval_nxt, snap_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   always_comb begin
      rise = i_en & ~en_d;
      fall = ~i_en & en_d;
      busy = |forced_r;
      rel_all = (mode_r == 2'd0) ? fall
              : (i_release | (mode_r == 2'd2 && busy && cnt_r == CNT_W'(1)));
      dep_clr = (mode_r == 2'd3) ? (i_drv ^ snap_r) : '0;
      forced_nxt = (rel_all ? '0 : (forced_r & ~dep_clr)) | (rise ? i_mask : '0);
      fval_nxt = rise ? ((fval_r & ~i_mask) | (i_val & i_mask)) : fval_r;
      snap_nxt = rise ? ((snap_r & ~i_mask) | (i_drv & i_mask)) : snap_r;
      cnt_nxt = rise ? ((i_hold == '0) ? CNT_W'(1) : i_hold)
              : !busy ? '0
              : (mode_r == 2'd2) ? (i_release ? '0 : cnt_r - CNT_W'(1))
              : cnt_r;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_d     <= 1'b0;
         forced_r <= '0;
         fval_r   <= '0;
         snap_r   <= '0;
         mode_r   <= 2'd0;
         cnt_r    <= '0;
      end else begin
         en_d     <= i_en;
         forced_r <= forced_nxt;
         fval_r   <= fval_nxt;
         snap_r   <= snap_nxt;
         mode_r   <= rise ? i_mode : mode_r;
         cnt_r    <= cnt_nxt;
      end
   end
   assign o_q      = (forced_r & fval_r) | (~forced_r & i_drv);
   assign o_forced = forced_r;
   assign o_busy   = |forced_r;
endmodule

// File: tb/tb_force_release_ctrl.sv
// tb_force_release_ctrl: directed vector table plus reset sequences for force_release_ctrl
module tb_force_release_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  drv = '0, val = '0, mask = '0;
   logic        en = 1'b0, rel = 1'b0;
   logic [1:0]  mode = '0;
   logic [15:0] hold = '0;
   logic [7:0]  q, forced;
   logic        busy;
   int          checks = 0, errors = 0;
   typedef struct {
      logic        en, rel;
      logic [1:0]  mode;
      logic [7:0]  val, mask, drv, q, forced;
      logic [15:0] hold;
   } vec_t;
   vec_t tv[33];
   force_release_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .i_drv(drv), .i_en(en), .i_val(val), .i_mask(mask),
      .i_mode(mode), .i_release(rel), .i_hold(hold), .o_q(q), .o_forced(forced), .o_busy(busy)
   );
   always #5 clk = ~clk;
   function automatic vec_t mk(logic e, logic r, logic [1:0] m, logic [7:0] v, logic [7:0] k,
                               logic [15:0] h, logic [7:0] d, logic [7:0] eq, logic [7:0] ef);
      vec_t t;
      t.en = e; t.rel = r; t.mode = m; t.val = v; t.mask = k;
      t.hold = h; t.drv = d; t.q = eq; t.forced = ef;
      return t;
   endfunction
   task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask
   initial begin
      // level
      tv[0]  = mk(1, 0, 0, 8'h05, 8'h0F, 0, 8'h00, 8'h05, 8'h0F);
      tv[1]  = mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h05, 8'h0F);
      tv[2]  = mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h05, 8'h0F);
      tv[3]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      tv[4]  = mk(0, 0, 0, 0, 0, 0, 8'h3C, 8'h3C, 8'h00);
      // sticky with re-arm
      tv[5]  = mk(1, 0, 1, 8'h03, 8'h03, 0, 8'h00, 8'h03, 8'h03);
      tv[6]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h03, 8'h03);
      tv[7]  = mk(1, 0, 1, 8'h80, 8'hC0, 0, 8'h00, 8'h83, 8'hC3);
      tv[8]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h83, 8'hC3);
      tv[9]  = mk(0, 0, 0, 0, 0, 0, 8'h44, 8'h87, 8'hC3);
      tv[10] = mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      // timed, hold 4 then hold 0
      tv[11] = mk(1, 0, 2, 8'hA5, 8'hFF, 4, 8'h00, 8'hA5, 8'hFF);
      tv[12] = mk(1, 0, 0, 0, 0, 0, 8'h00, 8'hA5, 8'hFF);
      tv[13] = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'hA5, 8'hFF);
      tv[14] = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'hA5, 8'hFF);
      tv[15] = mk(0, 0, 0, 0, 0, 0, 8'h11, 8'h11, 8'h00);
      tv[16] = mk(1, 0, 2, 8'hA5, 8'hFF, 0, 8'h11, 8'hA5, 8'hFF);
      tv[17] = mk(1, 0, 0, 0, 0, 0, 8'h11, 8'h11, 8'h00);
      tv[18] = mk(0, 0, 0, 0, 0, 0, 8'h11, 8'h11, 8'h00);
      // deposit
      tv[19] = mk(1, 0, 3, 8'hFF, 8'hFF, 0, 8'h00, 8'hFF, 8'hFF);
      tv[20] = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 8'hFF);
      tv[21] = mk(0, 0, 0, 0, 0, 0, 8'h01, 8'hFF, 8'hFE);
      tv[22] = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'hFE, 8'hFE);
      tv[23] = mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      // release coincident with rise
      tv[24] = mk(1, 0, 1, 8'h01, 8'h01, 0, 8'h00, 8'h01, 8'h01);
      tv[25] = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 8'h01);
      tv[26] = mk(1, 1, 1, 8'h10, 8'h10, 0, 8'h00, 8'h10, 8'h10);
      tv[27] = mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      // level ignores release
      tv[28] = mk(1, 0, 0, 8'h50, 8'hF0, 0, 8'h00, 8'h50, 8'hF0);
      tv[29] = mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h50, 8'hF0);
      tv[30] = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      // timed early abort
      tv[31] = mk(1, 0, 2, 8'h0A, 8'h0F, 10, 8'h00, 8'h0A, 8'h0F);
      tv[32] = mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      drv = 8'h69;
      repeat (2) @(negedge clk);
      chk("reset forced", forced, 8'h00);
      chk("reset busy", {7'd0, busy}, 8'h00);
      chk("reset q", q, 8'h69);
      drv = 8'h00;
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 33; i++) begin
         en = tv[i].en; rel = tv[i].rel; mode = tv[i].mode; val = tv[i].val;
         mask = tv[i].mask; hold = tv[i].hold; drv = tv[i].drv;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d q", i), q, tv[i].q);
         chk($sformatf("vec%0d forced", i), forced, tv[i].forced);
         chk($sformatf("vec%0d busy", i), {7'd0, busy}, {7'd0, |tv[i].forced});
         @(negedge clk);
      end
      // asynchronous reset during a long timed force
      en = 1'b1; rel = 1'b0; mode = 2'd2; hold = 16'd100; mask = 8'hFF; val = 8'h3C; drv = 8'h00;
      repeat (3) @(negedge clk);
      chk("timed long q", q, 8'h3C);
      en = 1'b1; mode = 2'd1; mask = 8'h0F; val = 8'h0F; drv = 8'h5A;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst forced", forced, 8'h00);
      chk("async rst q", q, 8'h5A);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("pre-edge forced", forced, 8'h00);
      @(posedge clk);
      #1;
      chk("re-apply forced", forced, 8'h0F);
      chk("re-apply q", q, 8'h5F);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #1;
      chk("sticky after reset forced", forced, 8'h0F);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
